// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - song ROM walker feeding note_player, plus note tick divider
module song_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_stb,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [3:0]        i_tempo,
  output logic [ADDR_W-1:0] o_song_addr,
  input  logic [15:0]       i_song_data,
  output logic              o_load,
  output logic [5:0]        o_pitch,
  output logic [4:0]        o_duration,
  output logic [3:0]        o_instrument,
  output logic              o_note_stb,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_song_end
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_LOAD,
    S_PLAY
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] word_q;
  logic        loop_flag_q;
  logic        play_hold_q;
  logic [3:0]  tempo_cnt_q;

  // Decoded view of the registered song word.
  logic is_ctrl;
  logic is_loop;
  logic take_jump;

  assign is_ctrl   = word_q[15];
  assign is_loop   = word_q[14];
  // A second control word straight after a jump ends the song instead of
  // jumping again, so a loop that never reaches a note cannot spin forever.
  assign take_jump = is_ctrl && is_loop && !loop_flag_q;

  assign o_busy     = (state_q != S_IDLE);
  assign o_note_stb = o_busy && i_frame_stb && (tempo_cnt_q == i_tempo);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and pulse outputs; stop beats start, start beats normal flow.
  always_comb begin
    state_d    = state_q;
    o_load     = 1'b0;
    o_song_end = 1'b0;
    if (i_stop) begin
      state_d = S_IDLE;
    end else if (i_start) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_IDLE;
        S_FETCH:  state_d = S_WAIT;
        S_WAIT:   state_d = S_DECODE;
        S_DECODE: begin
          if (!is_ctrl) begin
            state_d = S_LOAD;
          end else if (take_jump) begin
            state_d = S_FETCH;
          end else begin
            o_song_end = 1'b1;
            state_d    = S_IDLE;
          end
        end
        S_LOAD: begin
          o_load  = 1'b1;
          state_d = S_PLAY;
        end
        S_PLAY: begin
          // The player's done flag may still be high from the previous note
          // during the first PLAY cycle, so it is only honoured afterwards.
          if (!play_hold_q && i_done) begin
            state_d = S_FETCH;
          end
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Address, fetched word, loop guard and latched note fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_song_addr  <= '0;
      word_q       <= '0;
      loop_flag_q  <= 1'b0;
      play_hold_q  <= 1'b0;
      o_pitch      <= '0;
      o_duration   <= '0;
      o_instrument <= '0;
    end else begin
      play_hold_q <= (state_q == S_LOAD);
      if (i_stop) begin
        loop_flag_q <= 1'b0;
      end else if (i_start) begin
        o_song_addr <= i_base_addr;
        loop_flag_q <= 1'b0;
      end else begin
        case (state_q)
          S_WAIT: word_q <= i_song_data;
          S_DECODE: begin
            if (!is_ctrl) begin
              o_instrument <= word_q[14:11];
              o_pitch      <= word_q[10:5];
              o_duration   <= word_q[4:0];
              loop_flag_q  <= 1'b0;
            end else if (take_jump) begin
              o_song_addr <= word_q[ADDR_W-1:0];
              loop_flag_q <= 1'b1;
            end else begin
              loop_flag_q <= 1'b0;
            end
          end
          S_LOAD: o_song_addr <= o_song_addr + ADDR_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Tempo divider: counts frame strobes only while playing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tempo_cnt_q <= '0;
    end else if (i_start && !i_stop) begin
      tempo_cnt_q <= '0;
    end else if (o_busy && i_frame_stb) begin
      if (tempo_cnt_q == i_tempo) begin
        tempo_cnt_q <= '0;
      end else begin
        tempo_cnt_q <= tempo_cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - directed self-checking bench for song_sequencer
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_stb;
  logic        start;
  logic        stop;
  logic [7:0]  base;
  logic [3:0]  tempo;
  logic [7:0]  song_addr;
  logic [15:0] song_data;
  logic        load;
  logic [5:0]  pitch;
  logic [4:0]  dur;
  logic [3:0]  instr;
  logic        note_stb;
  logic        done;
  logic        busy;
  logic        song_end;

  song_sequencer #(.ADDR_W(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_stb  (frame_stb),
    .i_start      (start),
    .i_stop       (stop),
    .i_base_addr  (base),
    .i_tempo      (tempo),
    .o_song_addr  (song_addr),
    .i_song_data  (song_data),
    .o_load       (load),
    .o_pitch      (pitch),
    .o_duration   (dur),
    .o_instrument (instr),
    .o_note_stb   (note_stb),
    .i_done       (done),
    .o_busy       (busy),
    .o_song_end   (song_end)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:255];
  always @(posedge clk) song_data <= rom[song_addr];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_timer = 0;
  bit auto_done = 1'b0;

  logic [7:0] ld_addr  [$];
  logic [5:0] ld_pitch [$];
  logic [4:0] ld_dur   [$];
  logic [3:0] ld_instr [$];
  int         ld_cyc   [$];
  int         stb_at   [$];
  int         end_cnt = 0;
  int         stb_cnt = 0;
  int         strobe_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_note(input logic [3:0] i, input logic [5:0] p, input logic [4:0] d);
    return {1'b0, i, p, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ld_addr.delete(); ld_pitch.delete(); ld_dur.delete(); ld_instr.delete();
    ld_cyc.delete(); stb_at.delete();
    end_cnt = 0; stb_cnt = 0; strobe_idx = 0;
  endtask

  task automatic do_start(input logic [7:0] b);
    base = b;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (load) begin
      ld_addr.push_back(song_addr);
      ld_pitch.push_back(pitch);
      ld_dur.push_back(dur);
      ld_instr.push_back(instr);
      ld_cyc.push_back(cyc);
      if (auto_done) done_timer = 5;
    end
    if (song_end) end_cnt++;
    if (frame_stb) strobe_idx++;
    if (note_stb) begin
      stb_cnt++;
      stb_at.push_back(strobe_idx);
    end
  end

  initial begin
    done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done_timer > 0) begin
        done_timer--;
        done = (done_timer == 0);
      end else begin
        done = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_p [3];
    logic [4:0] exp_d [3];
    logic [3:0] exp_i [3];
    rst = 1'b1; start = 1'b0; stop = 1'b0; frame_stb = 1'b0;
    base = 8'h00; tempo = 4'd0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h8000;
    exp_i[0] = 4'd3;  exp_p[0] = 6'd42; exp_d[0] = 5'd17;
    exp_i[1] = 4'd9;  exp_p[1] = 6'd5;  exp_d[1] = 5'd1;
    exp_i[2] = 4'd15; exp_p[2] = 6'd63; exp_d[2] = 5'd31;
    for (int k = 0; k < 3; k++) rom[8'h10 + k] = mk_note(exp_i[k], exp_p[k], exp_d[k]);
    rom[8'h13] = 16'h8000;

    repeat (3) tick();
    check("reset_outs", {busy, load, song_end, note_stb, song_addr, pitch, dur, instr}, 32'd0);
    rst = 1'b0;
    tick();

    // three notes then an end word
    clear_logs(); auto_done = 1'b1; tempo = 4'd0;
    do_start(8'h10);
    for (int i = 0; i < 200 && busy; i++) tick();
    check("t1_busy_fell", busy, 0);
    check("t1_load_count", ld_addr.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (ld_addr.size() > k) begin
        check($sformatf("t1_addr%0d", k), ld_addr[k], 8'h10 + k);
        check($sformatf("t1_pitch%0d", k), ld_pitch[k], exp_p[k]);
        check($sformatf("t1_dur%0d", k), ld_dur[k], exp_d[k]);
        check($sformatf("t1_instr%0d", k), ld_instr[k], exp_i[k]);
      end
    end
    if (ld_cyc.size() > 1) begin
      check("t1_start_lat", ld_cyc[0] - start_cyc, 4);
      check("t1_load_spacing", ld_cyc[1] - ld_cyc[0], 9);
    end
    check("t1_song_end_cnt", end_cnt, 1);
    check("t1_end_addr", song_addr, 8'h13);

    // loop word at 0x12 back to 0x10
    rom[8'h12] = 16'hC010;
    clear_logs(); auto_done = 1'b1;
    do_start(8'h10);
    for (int i = 0; i < 400 && ld_addr.size() < 6; i++) tick();
    check("t2_load_count", ld_addr.size() >= 6, 1);
    for (int k = 0; k < 6; k++) begin
      if (ld_addr.size() > k) check($sformatf("t2_addr%0d", k), ld_addr[k], (k % 2 == 0) ? 8'h10 : 8'h11);
    end
    for (int k = 0; k < 3; k++) begin
      frame_stb = 1'b1; tick(); frame_stb = 1'b0; tick();
    end
    check("t2_tempo0_stb", stb_cnt, 3);
    check("t2_still_busy", busy, 1);
    auto_done = 1'b0;
    do_stop();
    done_timer = 0;
    check("t2_stop_idle", busy, 0);
    repeat (3) tick();
    check("t2_no_song_end", end_cnt, 0);

    // loop word targeting itself
    rom[8'h20] = 16'hC020;
    clear_logs();
    do_start(8'h20);
    for (int i = 0; i < 50 && busy; i++) tick();
    check("t3_idle", busy, 0);
    check("t3_song_end", end_cnt, 1);
    check("t3_no_load", ld_addr.size(), 0);

    // tempo 3, twelve strobes while playing, then stop and strobe while idle
    rom[8'h30] = mk_note(4'd5, 6'd20, 5'd10);
    rom[8'h31] = 16'h8000;
    tempo = 4'd3; auto_done = 1'b0;
    clear_logs();
    do_start(8'h30);
    for (int i = 0; i < 20 && ld_addr.size() < 1; i++) tick();
    check("t4_load_seen", ld_addr.size(), 1);
    for (int k = 0; k < 12; k++) begin
      frame_stb = 1'b1; tick(); frame_stb = 1'b0; tick();
    end
    check("t4_stb_cnt", stb_cnt, 3);
    for (int k = 0; k < 3; k++) begin
      if (stb_at.size() > k) check($sformatf("t4_stb_at%0d", k), stb_at[k], 4 * (k + 1));
    end
    do_stop();
    check("t4_stop_idle", busy, 0);
    for (int k = 0; k < 4; k++) begin
      frame_stb = 1'b1; tick(); frame_stb = 1'b0; tick();
    end
    check("t4_idle_no_stb", stb_cnt, 3);
    check("t4_no_song_end", end_cnt, 0);
    check("t4_pitch_hold", pitch, 6'd20);

    // start and stop together, while playing and while idle
    tempo = 4'd0;
    clear_logs();
    do_start(8'h30);
    for (int i = 0; i < 20 && ld_addr.size() < 1; i++) tick();
    tick();
    base = 8'h10; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t5_busy_next", busy, 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t5_idle_startstop", busy, 0);
    repeat (6) tick();
    check("t5_load_count", ld_addr.size(), 1);
    check("t5_no_song_end", end_cnt, 0);
    check("t5_fields_hold", {instr, pitch, dur}, {4'd5, 6'd20, 5'd10});

    // asynchronous reset mid-PLAY
    clear_logs();
    do_start(8'h30);
    for (int i = 0; i < 20 && ld_addr.size() < 1; i++) tick();
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_outs", {busy, load, song_end, note_stb, song_addr, pitch, dur, instr}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_after_rst", busy, 0);

    // address wrap from 0xFF to 0x00
    rom[8'hFF] = mk_note(4'd1, 6'd2, 5'd3);
    rom[8'h00] = 16'h8000;
    clear_logs(); auto_done = 1'b1;
    do_start(8'hFF);
    for (int i = 0; i < 100 && busy; i++) tick();
    auto_done = 1'b0;
    check("t7_load_count", ld_addr.size(), 1);
    if (ld_addr.size() > 0) check("t7_load_addr", ld_addr[0], 8'hFF);
    check("t7_wrap_addr", song_addr, 8'h00);
    check("t7_song_end", end_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
